// File: rtl/usb_obi_bridge.sv
// Register-mapped OBI bus master for the CW305 USB front-end: byte-wide host
// accesses build 32-bit address/data words and launch single OBI transactions.
module usb_obi_bridge #(
  parameter int pREG_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       reg_wr_i,
  input  logic                       reg_rd_i,
  input  logic [pREG_ADDR_WIDTH-1:0] reg_addr_i,
  input  logic [7:0]                 reg_wdata_i,
  output logic [7:0]                 reg_rdata_o,
  output logic                       bus_req_o,
  output logic                       bus_we_o,
  output logic [3:0]                 bus_be_o,
  output logic [31:0]                bus_addr_o,
  output logic [31:0]                bus_wdata_o,
  input  logic                       bus_gnt_i,
  input  logic                       bus_rvalid_i,
  input  logic [31:0]                bus_rdata_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [3:1]  ctrl_q;
  logic        done_q, timeout_q, overrun_q;
  logic [CNT_W-1:0] cnt_q;

  logic       hi_zero, idle, ctrl_wr, start_req, aw_req, launch_req, launch, launch_we, cnt_hit;
  logic [3:0] lo;
  logic [7:0] rd_mux;

  always_comb begin
    hi_zero    = (reg_addr_i >> 4) == '0;
    lo         = reg_addr_i[3:0];
    idle       = (state_q == S_IDLE);
    ctrl_wr    = reg_wr_i && hi_zero && (lo == 4'hC);
    start_req  = ctrl_wr && reg_wdata_i[0];
    aw_req     = reg_wr_i && hi_zero && (lo == 4'h7) && ctrl_q[3];
    launch_req = start_req || aw_req;
    launch     = launch_req && idle;
    launch_we  = aw_req ? 1'b1 : reg_wdata_i[1];
    cnt_hit    = (cnt_q == CNT_MAX);
  end

  always_comb begin
    rd_mux = 8'h00;
    if (hi_zero) begin
      case (lo)
        4'h0, 4'h1, 4'h2, 4'h3: rd_mux = addr_q[8*lo[1:0] +: 8];
        4'h4, 4'h5, 4'h6, 4'h7: rd_mux = wdata_q[8*lo[1:0] +: 8];
        4'h8, 4'h9, 4'hA, 4'hB: rd_mux = rdata_q[8*lo[1:0] +: 8];
        4'hC:    rd_mux = {4'h0, ctrl_q, 1'b0};
        4'hD:    rd_mux = {4'h0, overrun_q, timeout_q, done_q, busy_o};
        4'hE:    rd_mux = {4'h0, be_q};
        default: rd_mux = 8'h00;
      endcase
    end
  end

  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;
  assign err_o       = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      be_q        <= 4'hF;
      ctrl_q      <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      reg_rdata_o <= 8'h00;
    end else begin
      done_o <= 1'b0;
      if (reg_rd_i) reg_rdata_o <= rd_mux;

      // host register writes; data registers are frozen while a transaction is in flight
      if (ctrl_wr) begin
        ctrl_q <= reg_wdata_i[3:1];
        if (reg_wdata_i[7]) overrun_q <= 1'b0;
      end
      if (reg_wr_i && hi_zero && idle) begin
        case (lo[3:2])
          2'b00:   addr_q[8*lo[1:0] +: 8]  <= reg_wdata_i;
          2'b01:   wdata_q[8*lo[1:0] +: 8] <= reg_wdata_i;
          default: if (lo == 4'hE) be_q <= reg_wdata_i[3:0];
        endcase
      end
      if (launch_req && !idle) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q   <= S_REQ;
            bus_req_o <= 1'b1;
            bus_we_o  <= launch_we;
            busy_o    <= 1'b1;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (bus_gnt_i) begin
            state_q   <= S_WAIT;
            bus_req_o <= 1'b0;
            cnt_q     <= cnt_hit ? cnt_q : cnt_q + 1'b1;
          end else if (cnt_hit) begin
            state_q   <= S_IDLE;
            bus_req_o <= 1'b0;
            busy_o    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            done_q  <= 1'b1;
            if (!bus_we_o) rdata_q <= bus_rdata_i;
            if (ctrl_q[2]) addr_q <= addr_q + 32'd4;
          end else if (cnt_hit) begin
            state_q   <= S_IDLE;
            busy_o    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bus_req_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_obi_bridge.sv
// Directed self-checking bench for usb_obi_bridge with a small OBI slave model.
module tb_usb_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_wr_i, reg_rd_i;
  logic [7:0]  reg_addr_i, reg_wdata_i, reg_rdata_o;
  logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        busy_o, done_o, err_o;

  usb_obi_bridge #(.pREG_ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_wr_i(reg_wr_i), .reg_rd_i(reg_rd_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // OBI slave model: grants after gnt_wait idle req cycles, responds rv_delay cycles later
  bit          slave_on = 1'b0;
  int          gnt_wait = 0;
  int          rv_delay = 1;
  logic [31:0] slave_rdata = '0;
  int          req_cyc = 0, rv_wait = 0, txn_cnt = 0, done_cnt = 0;
  bit          pending = 1'b0;
  logic [31:0] log_addr [16];
  logic [31:0] log_wdata [16];
  logic        log_we [16];
  logic [3:0]  log_be [16];

  initial begin
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      if (!rst_ni) begin
        pending = 1'b0; req_cyc = 0;
      end else if (pending) begin
        if (rv_wait == 0) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = slave_rdata; pending = 1'b0;
        end else rv_wait--;
      end else if (bus_req_o && slave_on) begin
        if (req_cyc == gnt_wait) begin
          bus_gnt_i = 1'b1;
          log_addr[txn_cnt % 16] = bus_addr_o; log_wdata[txn_cnt % 16] = bus_wdata_o;
          log_we[txn_cnt % 16] = bus_we_o; log_be[txn_cnt % 16] = bus_be_o;
          txn_cnt++; pending = 1'b1; rv_wait = rv_delay - 1; req_cyc = 0;
        end else req_cyc++;
      end else req_cyc = 0;
    end
  end

  always @(negedge clk_i) if (done_o) done_cnt++;

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_i);
    reg_wr_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    @(negedge clk_i);
    reg_wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk_i);
    reg_rd_i = 1'b1; reg_addr_i = a;
    @(negedge clk_i);
    reg_rd_i = 1'b0;
    d = reg_rdata_o;
  endtask

  task automatic write_word(input logic [7:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) reg_write(base + 8'(i), w[8*i +: 8]);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("busy_bound", 32'(n < 200), 32'd1);
  endtask

  logic [7:0] rb;
  int n, base;

  initial begin
    rst_ni = 1'b0; reg_wr_i = 1'b0; reg_rd_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    chk("rst_req", bus_req_o, 0);      chk("rst_we", bus_we_o, 0);
    chk("rst_be", bus_be_o, 4'hF);     chk("rst_addr", bus_addr_o, 0);
    chk("rst_wdata", bus_wdata_o, 0);  chk("rst_rdata", reg_rdata_o, 0);
    chk("rst_busy", busy_o, 0);        chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    reg_read(8'h0E, rb); chk("rst_be_reg", rb, 8'h0F);
    reg_read(8'h0C, rb); chk("rst_ctrl", rb, 8'h00);
    reg_read(8'h20, rb); chk("unmapped", rb, 8'h00);

    // single write, grant after 2 cycles, rvalid one cycle later
    slave_on = 1'b1; gnt_wait = 2; rv_delay = 1;
    write_word(8'h00, 32'h0000_1000);
    write_word(8'h04, 32'hDEAD_BEEF);
    reg_write(8'h0C, 8'h03);
    chk("t1_req_n1", bus_req_o, 1); chk("t1_busy_n1", busy_o, 1);
    wait_idle(n);
    chk("t1_txn", txn_cnt, 1);       chk("t1_addr", log_addr[0], 32'h1000);
    chk("t1_wdata", log_wdata[0], 32'hDEAD_BEEF);
    chk("t1_we", log_we[0], 1);      chk("t1_be", log_be[0], 4'hF);
    @(negedge clk_i);
    chk("t1_done_cnt", done_cnt, 1); chk("t1_req_off", bus_req_o, 0);
    reg_read(8'h0D, rb); chk("t1_status", rb, 8'h02);

    // read, minimum latency transaction
    gnt_wait = 0; slave_rdata = 32'h1234_5678;
    write_word(8'h00, 32'h0000_2004);
    reg_write(8'h0C, 8'h01);
    wait_idle(n);
    chk("t2_busy_cycles", n, 2);
    chk("t2_addr", log_addr[1], 32'h2004); chk("t2_we", log_we[1], 0);
    reg_read(8'h08, rb); chk("t2_rd0", rb, 8'h78);
    reg_read(8'h09, rb); chk("t2_rd1", rb, 8'h56);
    reg_read(8'h0A, rb); chk("t2_rd2", rb, 8'h34);
    reg_read(8'h0B, rb); chk("t2_rd3", rb, 8'h12);

    // auto-write stream with auto-increment
    gnt_wait = 1;
    reg_write(8'h0C, 8'h0C);
    write_word(8'h00, 32'h0);
    base = txn_cnt;
    for (int i = 0; i < 3; i++) begin
      write_word(8'h04, 32'hA000_0000 + 32'(i));
      wait_idle(n);
    end
    chk("t3_txn", txn_cnt - base, 3);
    chk("t3_a0", log_addr[base], 32'h0);  chk("t3_a1", log_addr[base+1], 32'h4);
    chk("t3_a2", log_addr[base+2], 32'h8);
    chk("t3_d2", log_wdata[base+2], 32'hA000_0002); chk("t3_we2", log_we[base+2], 1);
    reg_read(8'h00, rb); chk("t3_addr0", rb, 8'h0C);
    reg_read(8'h01, rb); chk("t3_addr1", rb, 8'h00);

    // slave never grants: 16 req cycles then abort
    slave_on = 1'b0;
    write_word(8'h00, 32'h0000_3000);
    reg_write(8'h0C, 8'h01);
    n = 0;
    while (bus_req_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("t4_req_cycles", n, 16);
    chk("t4_busy", busy_o, 0); chk("t4_err", err_o, 1);
    reg_read(8'h0D, rb); chk("t4_status", rb, 8'h04);
    reg_read(8'h01, rb); chk("t4_addr1", rb, 8'h30);

    // START while busy is dropped; ADDR write while busy is ignored
    slave_on = 1'b1; gnt_wait = 5;
    write_word(8'h00, 32'h0000_4000);
    base = txn_cnt;
    reg_write(8'h0C, 8'h03);
    reg_write(8'h01, 8'h55);
    reg_write(8'h0C, 8'h03);
    chk("t5_addr_stable", bus_addr_o, 32'h4000);
    wait_idle(n);
    repeat (4) @(negedge clk_i);
    chk("t5_txn", txn_cnt - base, 1); chk("t5_addr", log_addr[base], 32'h4000);
    chk("t5_err", err_o, 0);
    reg_read(8'h0D, rb); chk("t5_status", rb, 8'h0A);
    reg_write(8'h0C, 8'h80);
    reg_read(8'h0D, rb); chk("t5_status_clr", rb, 8'h02);

    // address wrap with auto-increment
    gnt_wait = 0;
    write_word(8'h00, 32'hFFFF_FFFC);
    base = txn_cnt;
    reg_write(8'h0C, 8'h07);
    wait_idle(n);
    chk("t6_addr", log_addr[base], 32'hFFFF_FFFC);
    chk("t6_wrap_bus", bus_addr_o, 32'h0);
    reg_read(8'h00, rb); chk("t6_wrap0", rb, 8'h00);
    reg_read(8'h03, rb); chk("t6_wrap3", rb, 8'h00);

    // asynchronous reset in the middle of REQ
    slave_on = 1'b0;
    write_word(8'h04, 32'h0BAD_F00D);
    reg_write(8'h0C, 8'h03);
    @(negedge clk_i);
    chk("t7_req_before", bus_req_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t7_req", bus_req_o, 0);     chk("t7_busy", busy_o, 0);
    chk("t7_we", bus_we_o, 0);       chk("t7_be", bus_be_o, 4'hF);
    chk("t7_addr", bus_addr_o, 0);   chk("t7_wdata", bus_wdata_o, 0);
    chk("t7_err", err_o, 0);         chk("t7_rdata", reg_rdata_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/usb_obi_bridge.md
# usb_obi_bridge

Register-mapped bus master that lets the ChipWhisperer host load and inspect X-HEEP memory over the CW305 USB parallel interface. It sits between the USB register front-end (already synchronised into the system clock domain) and a spare OBI master port of the X-HEEP bus. It assembles byte-wide host writes into 32-bit address and data words and sequences single OBI transactions with an req/gnt/rvalid FSM, timeout and auto-increment. An auto-write mode streams program images without a per-word START.

## Interface
Parameters:
- pREG_ADDR_WIDTH, 8: width of the register-file byte address.
- TIMEOUT_CYCLES, 1024: cycles allowed from req assertion to rvalid before abort; must be ≥2.

Ports:
- Clock and reset (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- reg_wr_i  in  1  single-cycle register write strobe.
- reg_rd_i  in  1  single-cycle register read strobe.
- reg_addr_i  in  pREG_ADDR_WIDTH  register byte address.
- reg_wdata_i  in  8  write byte.
- reg_rdata_o  out  8  read byte, registered.
- bus_req_o  out  1  OBI request.
- bus_we_o  out  1  OBI write enable.
- bus_be_o  out  4  OBI byte enables.
- bus_addr_o  out  32  OBI address.
- bus_wdata_o  out  32  OBI write data.
- bus_gnt_i  in  1  OBI grant.
- bus_rvalid_i  in  1  OBI response valid.
- bus_rdata_i  in  32  OBI read data.
- busy_o  out  1  transaction in flight.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky timeout error.

## Operation
- Register map (byte addresses): 0x00–0x03 ADDR, LSB first. 0x04–0x07 WDATA. 0x08–0x0B RDATA (RO). 0x0C CTRL. 0x0D STATUS (RO). 0x0E BE[3:0], reset 0xF. All other addresses read 0x00, and writes to them are ignored.
- CTRL bits: [0] START (self-clearing, reads 0), [1] WE, [2] AUTOINC, [3] AUTOWRITE. Bits [3:1] are stored.
- STATUS bits: [0] busy, [1] done (sticky), [2] timeout, [3] overrun.
- Writing CTRL with START=1 while in IDLE launches one transaction. It clears the done and timeout bits and copies WE into the transaction.
- AUTOWRITE=1: a write to WDATA byte 3 (0x07) launches a write transaction (WE forced 1).
- Any launch while busy is dropped and sets overrun. Overrun is cleared only by writing CTRL with bit 7 = 1.
- Writes to ADDR, WDATA or BE while busy are ignored; bus outputs stay stable during a transaction.
- bus_be_o = BE. bus_addr_o = {ADDR[31:2], 2'b00}; the ADDR register itself keeps bits [1:0].
- FSM states:
  - IDLE: on launch → REQ.
  - REQ: bus_req_o=1. On gnt → WAIT. On timeout → IDLE.
  - WAIT: on rvalid, latch RDATA = bus_rdata_i (read transactions only), pulse done_o, set done → IDLE. On timeout → IDLE.
- The timeout counter is cleared on launch and increments every cycle in REQ or WAIT. Reaching TIMEOUT_CYCLES-1 aborts the transaction: deassert req, set timeout and err_o, no done pulse, no ADDR increment. A late rvalid arriving in IDLE is ignored.
- AUTOINC=1: ADDR += 4 (mod 2^32, wraps to 0) in the same cycle as a successful completion.
- rvalid in the same cycle as gnt is not legal OBI and is not expected; the bridge takes gnt first and consumes rvalid only from the WAIT state.

## Timing
- Reset values: bus_req_o=0, bus_we_o=0, bus_be_o=0xF, bus_addr_o=0, bus_wdata_o=0, reg_rdata_o=0, busy_o=0, done_o=0, err_o=0. ADDR, WDATA, RDATA and CTRL are all 0.
- Launch write in cycle N → bus_req_o=1 and busy_o=1 from N+1.
- gnt sampled high in cycle M → bus_req_o=0 in M+1.
- rvalid in cycle K → done_o=1, busy_o=0, and RDATA/ADDR updated in K+1.
- Minimum transaction, with gnt in the first req cycle and rvalid the next cycle: busy is high for 2 cycles.
- reg_rd_i in cycle N → reg_rdata_o valid in N+1; it holds until the next read.
- A STATUS read returns state as of cycle N. A register write in the same cycle is not reflected.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops bus_req_o. The bus slave is responsible for discarding any outstanding response.

## Test plan
- Write ADDR=0x0000_1000, WDATA=0xDEADBEEF, CTRL=0x03; slave grants after 2 cycles and gives rvalid 1 cycle later → one OBI write with addr 0x1000, wdata 0xDEADBEEF, be 0xF; done_o pulses once; STATUS=0x02.
- Read with ADDR=0x0000_2004, CTRL=0x01, slave returns 0x12345678 → reading 0x08..0x0B yields 0x78, 0x56, 0x34, 0x12.
- AUTOWRITE|AUTOINC (CTRL=0x0C), ADDR=0x0, stream 3 words of 4 bytes each → writes to 0x0, 0x4, 0x8; ADDR reads 0x0C.
- Slave never grants, TIMEOUT_CYCLES=16 → req drops after 16 cycles in REQ; STATUS=0x04; err_o=1; ADDR unchanged.
- Second START while busy → extra transaction not issued; STATUS bit 3 set; CTRL write of 0x80 clears it.
- ADDR=0xFFFF_FFFC with AUTOINC, successful write → ADDR wraps to 0x0000_0000; pulling rst_ni low mid-REQ makes bus_req_o 0 immediately and all outputs return to their reset values.
